// File: rtl/snake_pkg.sv
// Shared snake game types: direction encodings, controller states and
// default grid size used by the step controller, body, collision and render.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int DEFAULT_GRID_W = 32;
  localparam int DEFAULT_GRID_H = 24;

  // A turn is legal when it neither repeats the reference direction nor
  // reverses it (opposite directions differ only in bit 1).
  function automatic logic isLegalTurn(input dir_t refDir, input logic [1:0] req);
    logic [1:0] refBits;
    refBits = refDir;
    return (req != refBits) && (req != (refBits ^ 2'd2));
  endfunction

endpackage

// File: rtl/dir_queue.sv
// Two-entry FIFO of pending direction requests. Slot 0 always holds the
// oldest entry; o_newest exposes the most recently queued one so the
// caller can judge the legality of the next request against it.
module dir_queue
  import snake_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_flush,
  input  logic i_push,
  input  dir_t i_pushDir,
  input  logic i_pop,
  output dir_t o_oldest,
  output dir_t o_newest,
  output logic o_empty,
  output logic o_full
);

  dir_t       r_slot0;
  dir_t       r_slot1;
  logic [1:0] r_count;
  logic       w_pop;

  assign w_pop    = i_pop && (r_count != 2'd0);
  assign o_empty  = (r_count == 2'd0);
  assign o_full   = (r_count == 2'd2);
  assign o_oldest = r_slot0;
  assign o_newest = (r_count == 2'd2) ? r_slot1 : r_slot0;

  // Shift-style storage: a pop moves slot 1 down; a push lands in the first free slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot0 <= DIR_RIGHT;
      r_slot1 <= DIR_RIGHT;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({i_push, w_pop})
        2'b01: begin
          r_slot0 <= r_slot1;
          r_count <= r_count - 2'd1;
        end
        2'b10: begin
          if (r_count == 2'd0) begin
            r_slot0 <= i_pushDir;
            r_count <= 2'd1;
          end else if (r_count == 2'd1) begin
            r_slot1 <= i_pushDir;
            r_count <= 2'd2;
          end
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_slot0 <= i_pushDir;
          end else begin
            r_slot0 <= r_slot1;
            r_slot1 <= i_pushDir;
          end
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

endmodule

// File: rtl/snake_step_ctrl.sv
// Snake head movement controller. Each rising edge of the game clock yields
// one tick; while running, a tick pops a queued turn (if any) and steps the
// head one cell, wrapping at the grid edges.
module snake_step_ctrl
  import snake_pkg::*;
#(
  parameter int GRID_W  = DEFAULT_GRID_W,
  parameter int GRID_H  = DEFAULT_GRID_H,
  parameter int XW      = 5,
  parameter int YW      = 5,
  parameter int START_X = 16,
  parameter int START_Y = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_gameClock,
  input  logic          i_start,
  input  logic          i_pause,
  input  logic          i_restart,
  input  logic          i_dirReqValid,
  input  logic [1:0]    i_dirReq,
  output logic [XW-1:0] o_headX,
  output logic [YW-1:0] o_headY,
  output logic [1:0]    o_dir,
  output logic          o_step,
  output logic          o_wrapped,
  output logic          o_running
);

  localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(GRID_H - 1);
  localparam logic [XW-1:0] X_START = XW'(START_X);
  localparam logic [YW-1:0] Y_START = YW'(START_Y);

  logic          r_gcQ;
  state_t        r_state;
  dir_t          r_dir;
  logic [XW-1:0] r_headX;
  logic [YW-1:0] r_headY;
  logic          r_step;
  logic          r_wrapped;
  logic          r_running;

  logic          w_tick;
  logic          w_move;
  logic          w_qEmpty;
  logic          w_qFull;
  dir_t          w_qOldest;
  dir_t          w_qNewest;
  dir_t          w_refDir;
  dir_t          w_reqDir;
  logic          w_pop;
  logic          w_push;
  dir_t          w_newDir;
  logic [XW-1:0] w_nextX;
  logic [YW-1:0] w_nextY;
  logic          w_wrap;

  assign w_tick   = i_gameClock & ~r_gcQ;
  assign w_move   = w_tick && (r_state == ST_RUN) && !i_pause;
  assign w_pop    = w_move && !w_qEmpty;
  assign w_newDir = w_pop ? w_qOldest : r_dir;

  // Popping only removes the oldest entry, so the newest survivor (or the
  // direction just popped into r_dir) equals the pre-pop newest entry.
  assign w_refDir = w_qEmpty ? r_dir : w_qNewest;
  assign w_reqDir = dir_t'(i_dirReq);
  assign w_push   = i_dirReqValid && !i_restart && isLegalTurn(w_refDir, i_dirReq)
                    && (!w_qFull || w_pop);

  dir_queue u_dirQueue (
    .clk       (clk),
    .reset     (reset),
    .i_flush   (i_restart),
    .i_push    (w_push),
    .i_pushDir (w_reqDir),
    .i_pop     (w_pop),
    .o_oldest  (w_qOldest),
    .o_newest  (w_qNewest),
    .o_empty   (w_qEmpty),
    .o_full    (w_qFull)
  );

  // Next head cell in the post-pop direction, wrapping by explicit compare.
  always_comb begin
    w_nextX = r_headX;
    w_nextY = r_headY;
    w_wrap  = 1'b0;
    case (w_newDir)
      DIR_RIGHT: begin
        if (r_headX == X_MAX) begin
          w_nextX = '0;
          w_wrap  = 1'b1;
        end else begin
          w_nextX = r_headX + XW'(1);
        end
      end
      DIR_LEFT: begin
        if (r_headX == '0) begin
          w_nextX = X_MAX;
          w_wrap  = 1'b1;
        end else begin
          w_nextX = r_headX - XW'(1);
        end
      end
      DIR_DOWN: begin
        if (r_headY == Y_MAX) begin
          w_nextY = '0;
          w_wrap  = 1'b1;
        end else begin
          w_nextY = r_headY + YW'(1);
        end
      end
      default: begin
        if (r_headY == '0) begin
          w_nextY = Y_MAX;
          w_wrap  = 1'b1;
        end else begin
          w_nextY = r_headY - YW'(1);
        end
      end
    endcase
  end

  // Delay the game clock by one cycle so its rising edge becomes a one-cycle tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gcQ <= 1'b0;
    end else begin
      r_gcQ <= i_gameClock;
    end
  end

  // Run state machine, head position, direction and registered pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_dir     <= DIR_RIGHT;
      r_headX   <= X_START;
      r_headY   <= Y_START;
      r_step    <= 1'b0;
      r_wrapped <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_running <= (r_state == ST_RUN);
      if (i_restart) begin
        r_state   <= ST_IDLE;
        r_dir     <= DIR_RIGHT;
        r_headX   <= X_START;
        r_headY   <= Y_START;
        r_step    <= 1'b0;
        r_wrapped <= 1'b0;
      end else begin
        r_step    <= w_move;
        r_wrapped <= w_move && w_wrap;
        if (w_move) begin
          r_dir   <= w_newDir;
          r_headX <= w_nextX;
          r_headY <= w_nextY;
        end
        case (r_state)
          ST_IDLE: if (i_start) r_state <= ST_RUN;
          ST_RUN:  if (i_pause) r_state <= ST_HOLD;
          ST_HOLD: if (!i_pause) r_state <= ST_RUN;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_headX   = r_headX;
  assign o_headY   = r_headY;
  assign o_dir     = r_dir;
  assign o_step    = r_step;
  assign o_wrapped = r_wrapped;
  assign o_running = r_running;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Bench for snake_step_ctrl: a short directed start-and-move sequence, then
// randomized play checked cycle by cycle against a grid-level model.
module tb_snake_step_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       gameClock;
  logic       start;
  logic       pause;
  logic       restart;
  logic       dirReqValid;
  logic [1:0] dirReq;
  logic [4:0] headX;
  logic [4:0] headY;
  logic [1:0] dir;
  logic       step;
  logic       wrapped;
  logic       running;

  int total = 0;
  int bad   = 0;

  // Model state: plain integers and a queue of pending turns.
  int mX, mY, mDir, mState, mGcQ, mStep, mWrap, mRunning;
  int mQ[$];

  int gcCnt;

  snake_step_ctrl #(
    .GRID_W(32), .GRID_H(24), .XW(5), .YW(5), .START_X(16), .START_Y(12)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_gameClock   (gameClock),
    .i_start       (start),
    .i_pause       (pause),
    .i_restart     (restart),
    .i_dirReqValid (dirReqValid),
    .i_dirReq      (dirReq),
    .o_headX       (headX),
    .o_headY       (headY),
    .o_dir         (dir),
    .o_step        (step),
    .o_wrapped     (wrapped),
    .o_running     (running)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mX = 16; mY = 12; mDir = 1; mState = 0; mGcQ = 0;
    mStep = 0; mWrap = 0; mRunning = 0;
    mQ.delete();
  endtask

  // One clock edge of the game rules, using the inputs present at that edge.
  task automatic modelClock();
    int tick, move, refDir, nx, ny, req;
    tick = (gameClock && !mGcQ) ? 1 : 0;
    mGcQ = gameClock;
    mRunning = (mState == 1) ? 1 : 0;
    if (restart) begin
      mX = 16; mY = 12; mDir = 1; mState = 0;
      mStep = 0; mWrap = 0;
      mQ.delete();
      return;
    end
    move = (tick && mState == 1 && !pause) ? 1 : 0;
    mStep = move;
    mWrap = 0;
    if (move) begin
      if (mQ.size() > 0) mDir = mQ.pop_front();
      nx = mX + ((mDir == 1) ? 1 : (mDir == 3) ? -1 : 0);
      ny = mY + ((mDir == 2) ? 1 : (mDir == 0) ? -1 : 0);
      if (nx < 0 || nx >= 32 || ny < 0 || ny >= 24) mWrap = 1;
      mX = (nx + 32) % 32;
      mY = (ny + 24) % 24;
    end
    if (dirReqValid) begin
      req = dirReq;
      refDir = (mQ.size() > 0) ? mQ[$] : mDir;
      if (req != refDir && req != (refDir ^ 2) && mQ.size() < 2) mQ.push_back(req);
    end
    if (mState == 0 && start) mState = 1;
    else if (mState == 1 && pause) mState = 2;
    else if (mState == 2 && !pause) mState = 1;
  endtask

  task automatic compareAll();
    checkOutput("headX", headX, mX);
    checkOutput("headY", headY, mY);
    checkOutput("dir", dir, mDir);
    checkOutput("step", step, mStep);
    checkOutput("wrapped", wrapped, mWrap);
    checkOutput("running", running, mRunning);
  endtask

  // Drive one cycle of inputs, let the edge pass, then compare at the falling edge.
  task automatic applyStimulus(input bit st, input bit pa, input bit rs, input bit gc,
                               input bit v, input int rq);
    start       = st;
    pause       = pa;
    restart     = rs;
    gameClock   = gc;
    dirReqValid = v;
    dirReq      = 2'(rq);
    @(negedge clk);
    modelClock();
    compareAll();
  endtask

  initial begin
    bit pa, gc;
    reset = 1'b1;
    start = 1'b0; pause = 1'b0; restart = 1'b0;
    gameClock = 1'b0; dirReqValid = 1'b0; dirReq = 2'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    modelReset();
    checkOutput("rstX", headX, 16);
    checkOutput("rstY", headY, 12);
    checkOutput("rstDir", dir, 1);
    compareAll();

    // Directed: start, then three ticks march the head right.
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("seqX", headX, 16 + k);
      checkOutput("seqY", headY, 12);
      checkOutput("seqStep", step, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("seqIdleStep", step, 0);
    end

    // Randomized play.
    pa = 0; gc = 0; gcCnt = 2;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      gcCnt--;
      if (gcCnt == 0) begin
        gc = ~gc;
        gcCnt = $urandom_range(1, 4);
      end
      if ($urandom_range(0, 99) < 4) pa = ~pa;
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncX", headX, 16);
        checkOutput("asyncY", headY, 12);
        checkOutput("asyncDir", dir, 1);
        checkOutput("asyncStep", step, 0);
        checkOutput("asyncWrap", wrapped, 0);
        checkOutput("asyncRun", running, 0);
        modelReset();
        #1 reset = 1'b0;
      end
      applyStimulus($urandom_range(0, 9) < 3, pa, $urandom_range(0, 299) == 0, gc,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
